win3x3_stream_gen: RTL and testbench
====================================

Name: win3x3_stream_gen

Overview:
- Streaming 3x3 neighbourhood generator for the image filter pipeline.
- Accepts raster-order pixels over a valid/ready handshake and keeps the two previous rows in internal line buffers.
- Emits one packed 3x3 window per interior position, with backpressure support.
- Frame width and height are set at runtime, up to parameterised maxima, and are latched at start of frame.

Parameters:
DATA_W, 8, pixel width in bits
MAX_W, 256, maximum frame width; sets line-buffer depth
MAX_H, 256, maximum frame height
WB, $clog2(MAX_W+1), width of cfg_width and the column counter (localparam)
HB, $clog2(MAX_H+1), width of cfg_height and the row counter (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_width  in  WB  frame width; legal range 3..MAX_W
cfg_height  in  HB  frame height; legal range 3..MAX_H
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept the input pixel
in_data  in  DATA_W  input pixel
in_sof  in  1  marks the first pixel of a frame
out_valid  out  1  window valid
out_ready  in  1  downstream accepts the window
out_win  out  9*DATA_W  window; slice k=3r+c holds pixel (row-2+r, col-2+c); k=0 is top-left
out_last  out  1  marks the final window of the frame
busy  out  1  FSM is in RUN
err_cfg  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Clock and reset: clk; rst_n is synchronous, active-low.
- Reset values: out_valid=0, out_win=0, out_last=0, busy=0, err_cfg=0, state=IDLE, row=0, col=0. Line-buffer RAM contents are not reset.
- Accept rule: accept = in_valid & in_ready, where in_ready = ~out_valid | out_ready. This is a single output register stage.
- FSM state IDLE:
  - Accepted pixel without in_sof: discarded, no state change.
  - Accepted pixel with in_sof and legal cfg: latch cfg into W/H, go to RUN, and process the pixel as (0,0).
  - Accepted pixel with in_sof and illegal cfg (width or height <3 or > max): err_cfg=1 for one cycle, stay in IDLE, pixel discarded.
- FSM state RUN: busy=1.
  - Each accepted pixel at (row,col) does lb1[col]<=lb0[col] and lb0[col]<=in_data. Reads return the pre-write values, from a combinational array read.
  - Window column shift: the column holding the oldest data (window column 0) is discarded; columns 1 and 2 move to 0 and 1. The new column 2 is {lb1[col], lb0[col], in_data} for r=0,1,2.
  - col advances; at W-1 it wraps to 0 and row increments.
  - Accepted pixel (row,col)=(H-1,W-1): return to IDLE after that accept.
- Output:
  - The accepted pixel has row>=2 and col>=2: next cycle out_valid=1, out_win=updated window, out_last=(row==H-1 && col==W-1).
  - out_valid drops on an out_ready handshake unless a new window loads in the same cycle.
  - out_win and out_last stay stable while out_valid & ~out_ready.
- Latency: one cycle from the accepting edge of the completing pixel to out_valid.
- Window count: exactly (H-2)*(W-2) windows per frame. Windows never straddle rows, because the col>=2 gating discards wrap columns.
- Mid-frame in_sof while in RUN: abort the current frame and restart at (0,0) with freshly latched cfg.
  - If the new cfg is illegal: err_cfg pulses and the FSM goes to IDLE.
  - A pending output window is kept until it is taken. Stale line-buffer data is never exposed, because rows 0 and 1 rewrite every column before row 2 reads them.
- Config changes outside sof acceptance are ignored.
- Reset mid-frame: all of the above reset values apply on the next edge, and any pending window is lost.

Decomposition:
- Shared package win_pkg holds the localparams WIN_K=3, WIN_N=9, the slice index function idx(r,c)=3r+c, and an enum for the FSM (IDLE, RUN).
- One sub-module, line_buf_ram: single-port MAX_W x DATA_W array, combinational read, synchronous write.
  - Instantiated twice (lb0, lb1).

Test Plan:
1. Frame 4x4, pixels 0..15, out_ready=1. Expect 4 windows.
   - First: {0,1,2,4,5,6,8,9,10}.
   - Last: {5,6,7,9,10,11,13,14,15} with out_last=1.
   - busy=0 after the frame.
2. Same 4x4 frame with out_ready held low for 5 cycles after window 2 appears. Expect:
   - in_ready=0 for those cycles;
   - out_win stable;
   - all 4 windows delivered in order, none lost.
3. Frame 256x3 with a random ramp. Expect 254 windows, window j equal to columns j..j+2 of rows 0..2, and out_last only on the 254th.
4. 5x5 frame aborted by in_sof at pixel 7, then a full 3x3 frame of values 100..108. Expect exactly one window {100..108} with out_last after the restart.
5. cfg_width=2 at sof. Expect an err_cfg pulse, busy=0, no out_valid; the following sof with width=3, height=3 works normally.
6. rst_n low for 1 cycle mid-frame in a 6x6 frame. Expect out_valid=0 and busy=0 next cycle; a new 3x3 frame then yields one correct window.

Source files
------------

// File: rtl/win_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : win_pkg
//  Description : Shared definitions for the 3x3 window stream generator:
//                window geometry, packed-slice index helper and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package win_pkg;

    localparam int WIN_K = 3;             // window edge length
    localparam int WIN_N = WIN_K * WIN_K; // pixels per window

    // Slice index of window pixel (r,c) inside the packed window bus.
    // r=0 is the oldest row and c=0 the oldest column, so k=0 is top-left.
    function automatic int idx(input int r, input int c);
        return WIN_K * r + c;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/win3x3_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : win3x3_stream_gen_if
//  Description : Bus bundle of the 3x3 window stream generator: frame
//                configuration, pixel input handshake, window output
//                handshake and status.
//  Ports       : slave  - the generator (pixels in, windows out)
//                master - the environment driving pixels / taking windows
//  Revision    : 1.0 - initial release
// ============================================================================
interface win3x3_stream_gen_if
    import win_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 256,
    parameter int MAX_H  = 256
) ();

    localparam int WB = $clog2(MAX_W + 1);
    localparam int HB = $clog2(MAX_H + 1);

    logic [WB-1:0]           cfg_width;
    logic [HB-1:0]           cfg_height;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_sof;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIN_N*DATA_W-1:0] out_win;
    logic                    out_last;
    logic                    busy;
    logic                    err_cfg;

    modport slave (
        input  cfg_width, cfg_height, in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_win, out_last, busy, err_cfg
    );

    modport master (
        output cfg_width, cfg_height, in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_win, out_last, busy, err_cfg
    );

endinterface
`default_nettype wire

// File: rtl/line_buf_ram.sv
`default_nettype none
// ============================================================================
//  Module      : line_buf_ram
//  Description : Single-port line buffer, DEPTH x DATA_W. Combinational read
//                of the addressed word, synchronous write, so a read in the
//                write cycle returns the pre-write contents. Not reset.
//  Ports       : clk     - clock
//                i_we    - write enable
//                i_addr  - shared read/write address
//                i_wdata - write data
//                o_rdata - read data (current contents at i_addr)
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [AW-1:0]     i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/win3x3_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : win3x3_stream_gen
//  Description : Streaming 3x3 neighbourhood generator. Raster pixels come in
//                over valid/ready; the two previous rows live in two line
//                buffers; one packed window is emitted per interior position
//                through a single output register stage with backpressure.
//                Frame width/height are latched when the sof pixel is taken.
//  Ports       : clk   - clock
//                rst_n - synchronous active-low reset
//                bus   - slave side of win3x3_stream_gen_if:
//                        cfg_width/cfg_height  frame size (3..MAX)
//                        in_valid/in_ready/in_data/in_sof  pixel input
//                        out_valid/out_ready/out_win/out_last  window output
//                        busy (frame in progress), err_cfg (reject pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module win3x3_stream_gen
    import win_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 256,
    parameter int MAX_H  = 256
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    win3x3_stream_gen_if.slave bus
);

    localparam int WB = $clog2(MAX_W + 1);
    localparam int HB = $clog2(MAX_H + 1);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [WB-1:0] c_MIN_W = WB'(3);
    localparam logic [WB-1:0] c_MAX_W = WB'(MAX_W);
    localparam logic [HB-1:0] c_MIN_H = HB'(3);
    localparam logic [HB-1:0] c_MAX_H = HB'(MAX_H);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_next_state;
    logic   w_busy;

    logic [WB-1:0] r_w;
    logic [HB-1:0] r_h;
    logic [WB-1:0] r_col;
    logic [HB-1:0] r_row;

    logic [WB-1:0] w_w;
    logic [HB-1:0] w_h;
    logic [WB-1:0] w_col;
    logic [HB-1:0] w_row;

    logic w_in_ready;
    logic w_acc;
    logic w_sof_acc;
    logic w_cfg_ok;
    logic w_process;
    logic w_at_eol;
    logic w_at_eof;
    logic w_load;

    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;

    // Window columns 1 and 2 of the running window; column 0 is implicit
    // because it is discarded on every shift.
    logic [WIN_K-1:0][DATA_W-1:0] r_c1;
    logic [WIN_K-1:0][DATA_W-1:0] r_c2;
    logic [WIN_K-1:0][DATA_W-1:0] w_newcol;
    logic [WIN_N*DATA_W-1:0]      w_upd;

    logic                    r_out_valid;
    logic [WIN_N*DATA_W-1:0] r_out_win;
    logic                    r_out_last;
    logic                    r_err_cfg;

    // ------------------------------------------------------------------
    // Handshake and pixel qualification
    // ------------------------------------------------------------------
    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_sof_acc  = w_acc & bus.in_sof;

    assign w_cfg_ok = (bus.cfg_width  >= c_MIN_W) && (bus.cfg_width  <= c_MAX_W) &&
                      (bus.cfg_height >= c_MIN_H) && (bus.cfg_height <= c_MAX_H);

    // An sof pixel always restarts at (0,0) with the live cfg, whatever the
    // state; other pixels only count while a frame is running.
    assign w_process = w_sof_acc ? w_cfg_ok : (w_acc & w_busy);

    assign w_col = w_sof_acc ? '0 : r_col;
    assign w_row = w_sof_acc ? '0 : r_row;
    assign w_w   = w_sof_acc ? bus.cfg_width  : r_w;
    assign w_h   = w_sof_acc ? bus.cfg_height : r_h;

    assign w_at_eol = (w_col == w_w - WB'(1));
    assign w_at_eof = w_at_eol && (w_row == w_h - HB'(1));

    // Gating on col>=2 drops the two wrap positions at each row start, so a
    // window never mixes columns of different rows.
    assign w_load = w_process && (w_row >= HB'(2)) && (w_col >= WB'(2));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                // A legal sof cannot also be the last pixel (min frame 3x3).
                if (w_process) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_sof_acc && !w_cfg_ok) begin
                    w_next_state = IDLE;
                end else if (w_process && w_at_eof) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        unique case (r_state)
            IDLE:    w_busy = 1'b0;
            RUN:     w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Line buffers: lb0 holds the previous row, lb1 the one before it.
    // Both are addressed by the current column; lb1 takes lb0's old word.
    // ------------------------------------------------------------------
    line_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W),
        .AW     (AW)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_process),
        .i_addr  (w_col[AW-1:0]),
        .i_wdata (bus.in_data),
        .o_rdata (w_lb0_rd)
    );

    line_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W),
        .AW     (AW)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_process),
        .i_addr  (w_col[AW-1:0]),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // ------------------------------------------------------------------
    // Window assembly: incoming column is {row-2, row-1, current pixel}
    // ------------------------------------------------------------------
    assign w_newcol[0] = w_lb1_rd;
    assign w_newcol[1] = w_lb0_rd;
    assign w_newcol[2] = bus.in_data;

    for (genvar gr = 0; gr < WIN_K; gr++) begin : g_win_row
        assign w_upd[idx(gr, 0)*DATA_W +: DATA_W] = r_c1[gr];
        assign w_upd[idx(gr, 1)*DATA_W +: DATA_W] = r_c2[gr];
        assign w_upd[idx(gr, 2)*DATA_W +: DATA_W] = w_newcol[gr];
    end

    // ------------------------------------------------------------------
    // Position counters, latched geometry and window shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w   <= '0;
            r_h   <= '0;
            r_col <= '0;
            r_row <= '0;
            r_c1  <= '0;
            r_c2  <= '0;
        end else begin
            if (w_sof_acc && w_cfg_ok) begin
                r_w <= bus.cfg_width;
                r_h <= bus.cfg_height;
            end
            if (w_process) begin
                r_c1 <= r_c2;
                r_c2 <= w_newcol;
                if (w_at_eof) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (w_at_eol) begin
                    r_col <= '0;
                    r_row <= w_row + HB'(1);
                end else begin
                    r_col <= w_col + WB'(1);
                    r_row <= w_row;
                end
            end else if (w_sof_acc) begin
                // Rejected sof: park the position at the frame origin.
                r_col <= '0;
                r_row <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_win   <= '0;
            r_out_last  <= 1'b0;
            r_err_cfg   <= 1'b0;
        end else begin
            r_err_cfg <= w_sof_acc & ~w_cfg_ok;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_win   <= w_upd;
                r_out_last  <= w_at_eof;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_win   = r_out_win;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = w_busy;
    assign bus.err_cfg   = r_err_cfg;

endmodule
`default_nettype wire

// File: tb/tb_win3x3_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_win3x3_stream_gen
//  Description : Self-checking bench for win3x3_stream_gen. An image-level
//                model (frame array + position) predicts every output each
//                cycle; directed frames add hand-computed literal windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_win3x3_stream_gen;

    localparam int DATA_W = 8;
    localparam int MAX_W  = 256;
    localparam int MAX_H  = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    win3x3_stream_gen_if #(.DATA_W(DATA_W), .MAX_W(MAX_W), .MAX_H(MAX_H)) bus ();

    win3x3_stream_gen #(.DATA_W(DATA_W), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_err_seen = 0;
    bit chk_en = 0;
    bit rand_bp = 0;
    bit gap_en = 0;

    logic [71:0] got_win[$];
    bit          got_last[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 60) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // ------------------------------------------------------------------
    // Image-level model: remembers the pixels of the current frame and
    // builds each window directly from the frame array.
    // ------------------------------------------------------------------
    logic [7:0]  img [0:MAX_H-1][0:MAX_W-1];
    bit          m_active, m_valid, m_last, m_err;
    logic [71:0] m_win;
    int          mr, mc, mW, mH;

    always @(posedge clk) begin : model
        bit acc, pix, legal;
        if (!rst_n) begin
            m_active = 0; m_valid = 0; m_last = 0; m_err = 0; m_win = '0;
            mr = 0; mc = 0;
        end else begin
            acc   = bus.in_valid && (!m_valid || bus.out_ready);
            legal = (bus.cfg_width >= 3) && (bus.cfg_width <= MAX_W) &&
                    (bus.cfg_height >= 3) && (bus.cfg_height <= MAX_H);
            m_err = 0;
            pix   = 0;
            if (bus.out_ready) m_valid = 0;
            if (acc) begin
                if (bus.in_sof) begin
                    if (legal) begin
                        m_active = 1; mW = int'(bus.cfg_width); mH = int'(bus.cfg_height);
                        mr = 0; mc = 0; pix = 1;
                    end else begin
                        m_err = 1; m_active = 0;
                    end
                end else begin
                    pix = m_active;
                end
            end
            if (pix) begin
                img[mr][mc] = bus.in_data;
                if (mr >= 2 && mc >= 2) begin
                    m_valid = 1;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            m_win[(3*r + c)*8 +: 8] = img[mr-2+r][mc-2+c];
                    m_last = (mr == mH-1) && (mc == mW-1);
                end
                if (mr == mH-1 && mc == mW-1) m_active = 0;
                else if (mc == mW-1) begin mc = 0; mr++; end
                else mc++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model, plus delivery log
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  bus.in_ready,  !m_valid || bus.out_ready);
            chk("out_valid", bus.out_valid, m_valid);
            chk("busy",      bus.busy,      m_active);
            chk("err_cfg",   bus.err_cfg,   m_err);
            if (m_valid) begin
                chk("out_win",  bus.out_win,  m_win);
                chk("out_last", bus.out_last, m_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                got_win.push_back(bus.out_win);
                got_last.push_back(bus.out_last);
            end
            if (bus.err_cfg) n_err_seen++;
        end
    end

    // Random backpressure, applied after the driver's own updates.
    always @(posedge clk) begin
        #2;
        if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [7:0] d, input logic sof);
        bit rdy, done;
        if (gap_en && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        bus.in_valid = 1; bus.in_data = d; bus.in_sof = sof; done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk); rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) done = 1;
        end
        bus.in_valid = 0; bus.in_sof = 0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got no accept, expected accept within 2000 cycles");
        end
    endtask

    task automatic drain(input int n);
        if (!rand_bp) bus.out_ready = 1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_cfg(input int w, input int h);
        bus.cfg_width = 9'(w); bus.cfg_height = 9'(h);
    endtask

    task automatic stall_watch(input int b);
        int t;
        t = 0;
        while (got_win.size() < b + 1 && t < 300) begin @(posedge clk); #1; t++; end
        bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stall_in_ready",  bus.in_ready,  0);
            chk("t2_stall_out_valid", bus.out_valid, 1);
            chk("t2_stall_win", bus.out_win, pk(1, 2, 3, 5, 6, 7, 9, 10, 11));
            @(posedge clk); #1;
        end
        bus.out_ready = 1;
    endtask

    function automatic logic [7:0] ramp(input int base, input int r, input int c);
        return 8'((base + c + 7*r) & 255);
    endfunction

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 50000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : main
        int b, lastcnt, base, ew, eh, total, abort_at;
        logic [71:0] exp4[4];

        bus.in_valid = 0; bus.in_sof = 0; bus.in_data = 0; bus.out_ready = 1;
        set_cfg(4, 4);
        rst_n = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_win",   bus.out_win,   0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_err_cfg",   bus.err_cfg,   0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        exp4[0] = pk(0, 1, 2, 4, 5, 6, 8, 9, 10);
        exp4[1] = pk(1, 2, 3, 5, 6, 7, 9, 10, 11);
        exp4[2] = pk(4, 5, 6, 8, 9, 10, 12, 13, 14);
        exp4[3] = pk(5, 6, 7, 9, 10, 11, 13, 14, 15);

        // 1: 4x4 frame, no backpressure
        b = got_win.size();
        for (int i = 0; i < 16; i++) send(8'(i), i == 0);
        drain(4);
        chk("t1_count", got_win.size() - b, 4);
        chk("t1_first", got_win[b], exp4[0]);
        chk("t1_last_win", got_win[b+3], exp4[3]);
        chk("t1_first_not_last", got_last[b], 0);
        chk("t1_last_flag", got_last[b+3], 1);
        @(negedge clk);
        chk("t1_busy_after", bus.busy, 0);
        @(posedge clk); #1;

        // 2: same frame, 5-cycle stall while window 2 is presented
        b = got_win.size();
        fork
            for (int i = 0; i < 16; i++) send(8'(i), i == 0);
            stall_watch(b);
        join
        drain(4);
        chk("t2_count", got_win.size() - b, 4);
        for (int i = 0; i < 4; i++) chk("t2_order", got_win[b+i], exp4[i]);

        // 3: 256x3 random ramp under random backpressure and input gaps
        base = int'($urandom_range(0, 255));
        set_cfg(256, 3);
        rand_bp = 1; gap_en = 1;
        b = got_win.size();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 256; c++) send(ramp(base, r, c), r == 0 && c == 0);
        rand_bp = 0; gap_en = 0;
        drain(6);
        chk("t3_count", got_win.size() - b, 254);
        chk("t3_first", got_win[b], pk(ramp(base,0,0), ramp(base,0,1), ramp(base,0,2),
                                        ramp(base,1,0), ramp(base,1,1), ramp(base,1,2),
                                        ramp(base,2,0), ramp(base,2,1), ramp(base,2,2)));
        chk("t3_last_win", got_win[b+253], pk(ramp(base,0,253), ramp(base,0,254), ramp(base,0,255),
                                              ramp(base,1,253), ramp(base,1,254), ramp(base,1,255),
                                              ramp(base,2,253), ramp(base,2,254), ramp(base,2,255)));
        lastcnt = 0;
        for (int i = b; i < got_win.size(); i++) lastcnt += int'(got_last[i]);
        chk("t3_last_count", lastcnt, 1);
        chk("t3_last_flag", got_last[b+253], 1);

        // 4: 5x5 aborted at pixel 7 by a 3x3 frame of 100..108
        set_cfg(5, 5);
        b = got_win.size();
        for (int i = 0; i < 7; i++) send(8'(i), i == 0);
        set_cfg(3, 3);
        for (int i = 0; i < 9; i++) send(8'(100 + i), i == 0);
        drain(4);
        chk("t4_count", got_win.size() - b, 1);
        chk("t4_win", got_win[b], pk(100, 101, 102, 103, 104, 105, 106, 107, 108));
        chk("t4_last", got_last[b], 1);

        // 5: illegal width rejected, then a legal 3x3 frame
        set_cfg(2, 3);
        b = got_win.size();
        lastcnt = n_err_seen;
        send(8'd7, 1);
        send(8'd8, 0);
        send(8'd9, 0);
        drain(2);
        chk("t5_err_pulses", n_err_seen - lastcnt, 1);
        chk("t5_no_window", got_win.size() - b, 0);
        @(negedge clk);
        chk("t5_busy", bus.busy, 0);
        @(posedge clk); #1;
        set_cfg(3, 3);
        for (int i = 0; i < 9; i++) send(8'(20 + i), i == 0);
        drain(4);
        chk("t5_after_count", got_win.size() - b, 1);
        chk("t5_after_win", got_win[b], pk(20, 21, 22, 23, 24, 25, 26, 27, 28));

        // 6: reset mid-frame with a window pending
        set_cfg(6, 6);
        for (int i = 0; i < 21; i++) send(8'(200 + i), i == 0);
        bus.out_ready = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.out_ready = 1;
        b = got_win.size();
        set_cfg(3, 3);
        for (int i = 0; i < 9; i++) send(8'(50 + i), i == 0);
        drain(4);
        chk("t6_count", got_win.size() - b, 1);
        chk("t6_win", got_win[b], pk(50, 51, 52, 53, 54, 55, 56, 57, 58));

        // 7: random frames, random aborts/illegal cfg, cfg churn mid-frame
        rand_bp = 1; gap_en = 1;
        for (int f = 0; f < 10; f++) begin
            ew = int'($urandom_range(3, 9));
            eh = int'($urandom_range(3, 6));
            if ($urandom_range(0, 7) == 0) ew = int'($urandom_range(0, 2));
            set_cfg(ew, eh);
            total = ew * eh;
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total - 1)) : total;
            for (int i = 0; i < abort_at; i++) begin
                send(8'($urandom_range(0, 255)), i == 0);
                if (i == 0) set_cfg(int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
            end
        end
        rand_bp = 0; gap_en = 0;
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
